// File: rtl/ma_stage_ctrl_if.sv
// Bundle between the MA stage controller and its neighbours: EX/MA register,
// data memory and writeback. The slave view is the controller's own.
interface ma_stage_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        ma_ctrl;
  logic [2:0]        wb_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] store_data;
  logic [4:0]        rdst;
  logic [DATA_W-1:0] pc_link;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              wb_valid;
  logic [2:0]        wb_ctrl_o;
  logic [4:0]        wb_rdst;
  logic [DATA_W-1:0] wb_alu;
  logic [DATA_W-1:0] wb_mem;
  logic [DATA_W-1:0] wb_pc;
  logic              mem_err;

  modport slave (
    input  in_valid, ma_ctrl, wb_ctrl, alu_result, store_data, rdst, pc_link,
           mem_ack, mem_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
           wb_valid, wb_ctrl_o, wb_rdst, wb_alu, wb_mem, wb_pc, mem_err
  );

  modport master (
    output in_valid, ma_ctrl, wb_ctrl, alu_result, store_data, rdst, pc_link,
           mem_ack, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
           wb_valid, wb_ctrl_o, wb_rdst, wb_alu, wb_mem, wb_pc, mem_err
  );
endinterface

// File: rtl/ma_stage_ctrl.sv
// Memory-access stage controller: one req/ack transaction per memory op,
// stalls upstream while busy, and retires one registered result per instruction.
module ma_stage_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  ma_stage_ctrl_if.slave bus
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  // Abort fires on the BUSY edge where the counter would reach TIMEOUT.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            r_state, w_nxt;
  logic [7:0]        r_cnt;
  logic              w_acc, w_acc_mem, w_ack, w_abort;

  logic              r_mem_req, r_mem_we;
  logic [DATA_W-1:0] r_mem_addr, r_mem_wdata;
  logic              r_wb_valid, r_mem_err;
  logic [2:0]        r_wb_ctrl;
  logic [4:0]        r_wb_rdst;
  logic [DATA_W-1:0] r_wb_alu, r_wb_mem, r_wb_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_acc     = 1'b0;
    w_acc_mem = 1'b0;
    w_ack     = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_acc = bus.in_valid;
        if (bus.in_valid && bus.ma_ctrl[0]) begin
          w_acc_mem = 1'b1;
          w_nxt     = S_BUSY;
        end
      end
      S_BUSY: begin
        // An ack on the timeout edge takes priority over the abort.
        if (bus.mem_ack) begin
          w_ack = 1'b1;
          w_nxt = S_IDLE;
        end else if (r_cnt == TO_LAST) begin
          w_abort = 1'b1;
          w_nxt   = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wb_valid  <= 1'b0;
      r_mem_err   <= 1'b0;
      r_wb_ctrl   <= '0;
      r_wb_rdst   <= '0;
      r_wb_alu    <= '0;
      r_wb_mem    <= '0;
      r_wb_pc     <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_mem_err  <= 1'b0;

      if (w_acc) begin
        r_wb_ctrl <= bus.wb_ctrl;
        r_wb_rdst <= bus.rdst;
        r_wb_alu  <= bus.alu_result;
        r_wb_pc   <= bus.pc_link;
        r_wb_mem  <= '0;
        if (w_acc_mem) begin
          r_mem_req   <= 1'b1;
          r_mem_we    <= bus.ma_ctrl[1];
          r_mem_addr  <= bus.alu_result;
          r_mem_wdata <= bus.store_data;
          r_cnt       <= '0;
        end else begin
          r_wb_valid <= 1'b1;
        end
      end

      if (w_ack) begin
        r_wb_mem   <= r_mem_we ? '0 : bus.mem_rdata;
        r_wb_valid <= 1'b1;
        r_mem_req  <= 1'b0;
      end

      if (w_abort) begin
        r_wb_ctrl[0] <= 1'b0;
        r_wb_mem     <= '0;
        r_wb_valid   <= 1'b1;
        r_mem_err    <= 1'b1;
        r_mem_req    <= 1'b0;
      end else if (r_state == S_BUSY && !bus.mem_ack) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.wb_valid  = r_wb_valid;
  assign bus.wb_ctrl_o = r_wb_ctrl;
  assign bus.wb_rdst   = r_wb_rdst;
  assign bus.wb_alu    = r_wb_alu;
  assign bus.wb_mem    = r_wb_mem;
  assign bus.wb_pc     = r_wb_pc;
  assign bus.mem_err   = r_mem_err;

endmodule

// File: tb/tb_ma_stage_ctrl.sv
// Cycle-table bench for ma_stage_ctrl (TIMEOUT=4): each row is one clock of
// inputs with the outputs expected just after that edge.
module tb_ma_stage_ctrl;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ma_stage_ctrl_if #(.DATA_W(DW)) bus ();

  ma_stage_ctrl #(.DATA_W(DW), .TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic          iv;
    logic [1:0]    ma;
    logic [2:0]    wb;
    logic [DW-1:0] alu;
    logic [DW-1:0] sd;
    logic [4:0]    rd;
    logic [DW-1:0] pc;
    logic          ack;
    logic [DW-1:0] rdata;
    logic          e_wbv;
    logic          e_rdy;
    logic          e_req;
    logic          e_we;
    logic [DW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [2:0]    e_wbctrl;
    logic [4:0]    e_rd;
    logic [DW-1:0] e_alu;
    logic [DW-1:0] e_mem;
    logic [DW-1:0] e_pc;
    logic          e_err;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   row    = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d actual=%h required=%h", name, row, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic iv, input logic [1:0] ma, input logic [2:0] wb,
    input logic [DW-1:0] alu, input logic [DW-1:0] sd, input logic [4:0] rd,
    input logic [DW-1:0] pc, input logic ack, input logic [DW-1:0] rdata,
    input logic e_wbv, input logic e_rdy, input logic e_req, input logic e_we,
    input logic [DW-1:0] e_addr, input logic [DW-1:0] e_wdata,
    input logic [2:0] e_wbctrl, input logic [4:0] e_rd, input logic [DW-1:0] e_alu,
    input logic [DW-1:0] e_mem, input logic [DW-1:0] e_pc, input logic e_err);
    vec_t v;
    v.iv = iv; v.ma = ma; v.wb = wb; v.alu = alu; v.sd = sd; v.rd = rd;
    v.pc = pc; v.ack = ack; v.rdata = rdata;
    v.e_wbv = e_wbv; v.e_rdy = e_rdy; v.e_req = e_req; v.e_we = e_we;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_wbctrl = e_wbctrl;
    v.e_rd = e_rd; v.e_alu = e_alu; v.e_mem = e_mem; v.e_pc = e_pc; v.e_err = e_err;
    return v;
  endfunction

  // Quiet cycle (no valid, no ack) with only the handshake outputs specified.
  function automatic vec_t idle(input logic e_rdy, input logic e_req, input logic e_we,
                                input logic [DW-1:0] e_addr, input logic [DW-1:0] e_wdata);
    return mk(0, 2'b00, 3'b000, '0, '0, 5'd0, '0, 0, '0,
              0, e_rdy, e_req, e_we, e_addr, e_wdata, 3'b000, 5'd0, '0, '0, '0, 0);
  endfunction

  task automatic drive(input vec_t v);
    bus.in_valid   = v.iv;
    bus.ma_ctrl    = v.ma;
    bus.wb_ctrl    = v.wb;
    bus.alu_result = v.alu;
    bus.store_data = v.sd;
    bus.rdst       = v.rd;
    bus.pc_link    = v.pc;
    bus.mem_ack    = v.ack;
    bus.mem_rdata  = v.rdata;
  endtask

  task automatic check_row(input vec_t v);
    chk("wb_valid", DW'(bus.wb_valid), DW'(v.e_wbv));
    chk("in_ready", DW'(bus.in_ready), DW'(v.e_rdy));
    chk("mem_req",  DW'(bus.mem_req),  DW'(v.e_req));
    chk("mem_err",  DW'(bus.mem_err),  DW'(v.e_err));
    if (v.e_req) begin
      chk("mem_we",    DW'(bus.mem_we), DW'(v.e_we));
      chk("mem_addr",  bus.mem_addr,    v.e_addr);
      chk("mem_wdata", bus.mem_wdata,   v.e_wdata);
    end
    if (v.e_wbv) begin
      chk("wb_ctrl_o", DW'(bus.wb_ctrl_o), DW'(v.e_wbctrl));
      chk("wb_rdst",   DW'(bus.wb_rdst),   DW'(v.e_rd));
      chk("wb_alu",    bus.wb_alu,         v.e_alu);
      chk("wb_mem",    bus.wb_mem,         v.e_mem);
      chk("wb_pc",     bus.wb_pc,          v.e_pc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wb_valid"}, DW'(bus.wb_valid), '0);
    chk({tag, "_mem_req"},  DW'(bus.mem_req),  '0);
    chk({tag, "_mem_we"},   DW'(bus.mem_we),   '0);
    chk({tag, "_mem_err"},  DW'(bus.mem_err),  '0);
    chk({tag, "_mem_addr"}, bus.mem_addr,      '0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata,    '0);
    chk({tag, "_wb_ctrl_o"}, DW'(bus.wb_ctrl_o), '0);
    chk({tag, "_wb_rdst"},  DW'(bus.wb_rdst),  '0);
    chk({tag, "_wb_alu"},   bus.wb_alu,        '0);
    chk({tag, "_wb_mem"},   bus.wb_mem,        '0);
    chk({tag, "_wb_pc"},    bus.wb_pc,         '0);
    chk({tag, "_in_ready"}, DW'(bus.in_ready), 32'd1);
  endtask

  initial begin
    // ADD, then an idle cycle.
    tbl.push_back(mk(1, 2'b00, 3'b011, 32'h15, 32'h0, 5'd3, 32'h0, 0, '0,
                     1, 1, 0, 0, '0, '0, 3'b011, 5'd3, 32'h15, 32'h0, 32'h0, 0));
    tbl.push_back(idle(1, 0, 0, '0, '0));
    // LD acked on the third BUSY edge; in_valid junk while busy must be ignored.
    tbl.push_back(mk(1, 2'b01, 3'b101, 32'h100, 32'h0, 5'd7, 32'h44, 0, '0,
                     0, 0, 1, 0, 32'h100, 32'h0, 3'b000, 5'd0, '0, '0, '0, 0));
    tbl.push_back(mk(1, 2'b11, 3'b011, 32'h999, 32'h7, 5'd2, 32'h0, 0, '0,
                     0, 0, 1, 0, 32'h100, 32'h0, 3'b000, 5'd0, '0, '0, '0, 0));
    tbl.push_back(idle(0, 1, 0, 32'h100, 32'h0));
    tbl.push_back(mk(0, 2'b00, 3'b000, '0, '0, 5'd0, '0, 1, 32'hDEADBEEF,
                     1, 1, 0, 0, '0, '0, 3'b101, 5'd7, 32'h100, 32'hDEADBEEF, 32'h44, 0));
    // ST acked on the first BUSY edge; load data must not leak into wb_mem.
    tbl.push_back(mk(1, 2'b11, 3'b000, 32'h40, 32'h55, 5'd0, 32'h8, 0, '0,
                     0, 0, 1, 1, 32'h40, 32'h55, 3'b000, 5'd0, '0, '0, '0, 0));
    tbl.push_back(mk(0, 2'b00, 3'b000, '0, '0, 5'd0, '0, 1, 32'h12345678,
                     1, 1, 0, 0, '0, '0, 3'b000, 5'd0, 32'h40, 32'h0, 32'h8, 0));
    // LD that times out: mem_req for exactly 4 cycles, then abort.
    tbl.push_back(mk(1, 2'b01, 3'b011, 32'h200, 32'h0, 5'd9, 32'h80, 0, '0,
                     0, 0, 1, 0, 32'h200, 32'h0, 3'b000, 5'd0, '0, '0, '0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(idle(0, 1, 0, 32'h200, 32'h0));
    tbl.push_back(mk(0, 2'b00, 3'b000, '0, '0, 5'd0, '0, 0, '0,
                     1, 1, 0, 0, '0, '0, 3'b010, 5'd9, 32'h200, 32'h0, 32'h80, 1));
    tbl.push_back(idle(1, 0, 0, '0, '0));
    // Stray ack while idle.
    tbl.push_back(mk(0, 2'b00, 3'b000, '0, '0, 5'd0, '0, 1, 32'hABCD,
                     0, 1, 0, 0, '0, '0, 3'b000, 5'd0, '0, '0, '0, 0));
    // Four back-to-back non-memory ops, the last a NOP.
    for (int i = 1; i <= 4; i++) begin
      logic [2:0] w;
      w = (i == 4) ? 3'b000 : 3'b011;
      tbl.push_back(mk(1, 2'b00, w, 32'h10 + 32'(i), 32'h0, 5'(i), 32'h1000 + 32'(i), 0, '0,
                       1, 1, 0, 0, '0, '0, w, 5'(i), 32'h10 + 32'(i), 32'h0,
                       32'h1000 + 32'(i), 0));
    end
    tbl.push_back(idle(1, 0, 0, '0, '0));
    // LD whose ack lands on the timeout edge: normal completion, no error.
    tbl.push_back(mk(1, 2'b01, 3'b111, 32'h300, 32'h0, 5'd12, 32'h90, 0, '0,
                     0, 0, 1, 0, 32'h300, 32'h0, 3'b000, 5'd0, '0, '0, '0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(idle(0, 1, 0, 32'h300, 32'h0));
    tbl.push_back(mk(0, 2'b00, 3'b000, '0, '0, 5'd0, '0, 1, 32'hCAFEF00D,
                     1, 1, 0, 0, '0, '0, 3'b111, 5'd12, 32'h300, 32'hCAFEF00D, 32'h90, 0));
    tbl.push_back(idle(1, 0, 0, '0, '0));

    // Reset state.
    drive(idle(1, 0, 0, '0, '0));
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) begin
      row = i;
      drive(tbl[i]);
      @(posedge clk);
      #1 check_row(tbl[i]);
    end

    // Reset in the middle of a LD: outputs clear at once, nothing retires.
    row = 1000;
    drive(mk(1, 2'b01, 3'b011, 32'h500, 32'h0, 5'd4, 32'hA0, 0, '0,
             0, 0, 1, 0, 32'h500, 32'h0, 3'b000, 5'd0, '0, '0, '0, 0));
    @(posedge clk);
    #1 chk("mid_req", DW'(bus.mem_req), 32'd1);
    drive(idle(0, 1, 0, 32'h500, 32'h0));
    @(posedge clk);
    #1 chk("mid_busy_ready", DW'(bus.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5A5A5A5A;
    @(posedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      row = 1001 + i;
      @(posedge clk);
      #1;
      chk("post_rst_wb_valid", DW'(bus.wb_valid), '0);
      chk("post_rst_mem_err",  DW'(bus.mem_err),  '0);
      chk("post_rst_in_ready", DW'(bus.in_ready), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
